// File: rtl/processador_pio_in_irq.sv
`timescale 1ns/1ps
// Avalon-MM PIO input port: synchronised inputs, per-bit edge capture (W1C), interrupt mask, level irq.
// Latency: in_port -> capture/irq/data read in 2 clocks (+DEBOUNCE_CYCLES when PIO_IN_DEBOUNCE_EN is defined); reads 1 clock.
// Backpressure: none; the slave accepts every access with no wait states.
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN adds a per-bit debounce filter between the synchronizer and the data value.
module processador_pio_in_irq #(
  parameter int WIDTH           = 3,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  // Register map word addresses.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Elaboration-time guards on parameter ranges.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("processador_pio_in_irq: WIDTH must be 1..32");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("processador_pio_in_irq: EDGE_TYPE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
    $error("processador_pio_in_irq: DEBOUNCE_CYCLES must be 1..255");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_next;
  logic             wr_en;

  // Bring the asynchronous pins into the clk domain before anything looks at them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  // Counter just wide enough to hold DEBOUNCE_CYCLES; the filtered bit flips on the
  // DEBOUNCE_CYCLES-th consecutive clock that sync2 disagrees with it.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb_q;

    // Per-bit filter: any disagreement-free clock restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        deb_q <= 1'b0;
      end else if (sync2[gi] == deb_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb_q <= sync2[gi];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign data[gi] = deb_q;
  end
`else
  // No filtering: the data value is the synchronizer output.
  assign data = sync2;
`endif

  // Remember last cycle's data so edges can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= data;
    end
  end

  // Edge detector selected by EDGE_TYPE (0 rising, 1 falling, 2 either).
  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0) begin
      edge_hit = data & ~prev;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~data & prev;
    end else begin
      edge_hit = data ^ prev;
    end
  end

  assign wr_en = chipselect & ~write_n;

  // Write-1-to-clear mask for the capture register; zero when not writing it.
  always_comb begin
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGE) begin
      clr_bits = writedata[WIDTH-1:0];
    end
  end

  // Capture register: a new edge wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux; unused upper bits and the reserved word read as zero.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = data;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      default:   rd_next = '0;
    endcase
  end

  // Registered read data, loaded every clock regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  // Level interrupt purely from registered state.
  assign irq = |(edge_capture & irq_mask);

  // Write data above WIDTH carries no meaning for this port.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = |writedata[31:WIDTH];
  end

endmodule

// File: doc/processador_pio_in_irq.md
PROCESSADOR_PIO_IN_IRQ -- requirements
Module: processador_pio_in_irq

Interface
REQ-001 Parameter WIDTH, default 3, number of input bits; legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, filter length in clocks; legal range 1..255; used only when the macro in REQ-022 is defined.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  2  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select; qualifies writes.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data; bits [31:WIDTH] ignored.
REQ-010 in_port  in  WIDTH  asynchronous external inputs.
REQ-011 readdata  out  32  registered read data; bits [31:WIDTH] always 0.
REQ-012 irq  out  1  level interrupt request, active-high.

Function
REQ-013 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 The data value SHALL be sync2, or the debounced value when REQ-022 applies; the previous data value SHALL be kept in register prev.
REQ-015 Register map: 0 = data (RO); 1 = reserved, reads 0, writes ignored; 2 = irq_mask (RW); 3 = edge_capture (RW, write-1-to-clear).
REQ-016 readdata SHALL load the addressed register every clock, independent of chipselect: read latency 1 cycle, with the value taken from the cycle address is presented.
REQ-017 A write SHALL occur on a clock where chipselect=1 and write_n=0. Address 2 loads irq_mask from writedata[WIDTH-1:0]. Address 3 clears each edge_capture bit whose writedata bit is 1.
REQ-018 A capture bit SHALL set when data and prev differ in the direction selected by EDGE_TYPE. If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-019 irq SHALL equal the OR of (edge_capture AND irq_mask), decoded combinationally from registers. It SHALL not depend on address, chipselect or writedata.
REQ-020 Latency without debounce: in_port stable before clock edge k -> sync2 at k+1 -> capture bit and irq at k+2 -> readdata (address 0) at k+2.
REQ-021 Input pulses shorter than one clock period SHALL not be guaranteed to capture; pulses of 2 or more clocks SHALL always capture.

Configuration
REQ-022 Macro PIO_IN_DEBOUNCE_EN defined: each bit has its own counter of width ceil(log2(DEBOUNCE_CYCLES+1)). The counter SHALL count while sync2 differs from the debounced bit and SHALL clear when they agree. The debounced bit SHALL take the sync2 value when the count reaches DEBOUNCE_CYCLES, and the counter SHALL then clear. This adds DEBOUNCE_CYCLES clocks to the REQ-020 latency.
REQ-023 Macro PIO_IN_DEBOUNCE_EN undefined: no counters are instantiated, data = sync2, and DEBOUNCE_CYCLES has no effect.

Reset
REQ-024 When reset=1, sync1, sync2, prev, the debounced value, the counters, irq_mask, edge_capture and readdata SHALL all clear to 0 immediately, without waiting for a clock edge. irq SHALL therefore be 0.
REQ-025 After reset deasserts, in_port bits already high SHALL set capture bits once sync2 rises, when EDGE_TYPE is 0 or 2.
REQ-026 Reset asserted mid-debounce or mid-write SHALL abandon the operation with no partial update.

Verification (WIDTH=3, EDGE_TYPE=0 unless stated)
REQ-027 in_port 000->101 held; read address 0 -> readdata=0x5 two clocks after the change and onward; edge_capture=0x5.
REQ-028 Write 0x4 to address 2, raise in_port bit 2 -> irq=1 at k+2; write 0x4 to address 3 -> irq=0 the next clock.
REQ-029 In the same cycle, a write of 0x1 to address 3 and a new rising edge on bit 0 -> edge_capture bit 0 stays 1.
REQ-030 EDGE_TYPE=1: in_port 111->110 -> edge_capture=0x1; 110->111 -> no new capture bit.
REQ-031 PIO_IN_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4: a 3-clock glitch on bit 1 -> no data change and no capture; a 6-clock pulse -> readdata bit 1 set 6 clocks after the input edge.
REQ-032 Assert reset for 1 ns mid-operation with irq=1 -> irq, readdata, irq_mask and edge_capture read 0 immediately after.
